// File: rtl/fwd_track_unit_pkg.sv
// Shared types and helpers for the forwarding/hazard tracker.
// Holds the tracker entry layout and the bypass-select width rule.
package fwd_pkg;

    localparam int SEL_RF = 0;

    // Upper bound on register address width; entries zero-extend into it.
    localparam int DST_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic                 load;
        logic [DST_MAX_W-1:0] dst;
    } TrackEntry;

    function automatic int selWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_track_unit_if.sv
// Issue-side bundle between the ID stage and the forwarding unit.
// Statistics counters appear only when FWD_STATS_EN is defined.
interface fwd_track_unit_if
    import fwd_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2
) ();

    localparam int SEL_W = selWidth(DEPTH);

    logic                     issue_valid;
    logic                     issue_wr;
    logic                     issue_load;
    logic [REG_W-1:0]         issue_dst;
    logic [NUM_SRC*REG_W-1:0] src_addr;
    logic [NUM_SRC-1:0]       src_used;
    logic                     hold_i;
    logic                     flush_i;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall_o;
`ifdef FWD_STATS_EN
    logic [15:0]              stall_cnt;
    logic [15:0]              fwd_cnt;

    modport master (
        output issue_valid, issue_wr, issue_load, issue_dst,
               src_addr, src_used, hold_i, flush_i,
        input  fwd_sel, stall_o, stall_cnt, fwd_cnt
    );

    modport slave (
        input  issue_valid, issue_wr, issue_load, issue_dst,
               src_addr, src_used, hold_i, flush_i,
        output fwd_sel, stall_o, stall_cnt, fwd_cnt
    );
`else
    modport master (
        output issue_valid, issue_wr, issue_load, issue_dst,
               src_addr, src_used, hold_i, flush_i,
        input  fwd_sel, stall_o
    );

    modport slave (
        input  issue_valid, issue_wr, issue_load, issue_dst,
               src_addr, src_used, hold_i, flush_i,
        output fwd_sel, stall_o
    );
`endif

endinterface

// File: rtl/fwd_track_unit_match.sv
// Per-operand youngest-writer search over the in-flight tracker.
// Reports the matching stage index (0 = register file) and whether it is a load.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int DEPTH = 2,
    localparam int SEL_W = selWidth(DEPTH)
) (
    input  TrackEntry [DEPTH-1:0] entries,
    input  logic [REG_W-1:0]      srcAddr,
    input  logic                  srcUsed,
    output logic [SEL_W-1:0]      matchSel,
    output logic                  matchLoad
);

    logic found;

    // Scan from stage 1 outward and stop at the first hit so the youngest writer wins.
    always_comb begin
        matchSel  = SEL_W'(SEL_RF);
        matchLoad = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && srcUsed && entries[k].valid && entries[k].wr &&
                entries[k].dst != '0 && entries[k].dst == DST_MAX_W'(srcAddr)) begin
                found     = 1'b1;
                matchSel  = SEL_W'(k + 1);
                matchLoad = entries[k].load;
            end
        end
    end

endmodule

// File: rtl/fwd_track_unit.sv
// Forwarding and load-use hazard unit with its own record of in-flight writes.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_track_unit
    import fwd_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int NUM_SRC  = 3,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fwd_track_unit_if.slave bus
);

    localparam int SEL_W = selWidth(DEPTH);
    localparam logic [SEL_W-1:0] LOAD_LAT_SEL = SEL_W'(LOAD_LAT);

    if (LOAD_LAT < 1 || LOAD_LAT > DEPTH) begin : gBadLoadLat
        $error("fwd_track_unit: LOAD_LAT must lie within 1..DEPTH");
    end
    if (REG_W > DST_MAX_W) begin : gBadRegW
        $error("fwd_track_unit: REG_W exceeds DST_MAX_W");
    end

    TrackEntry [DEPTH-1:0] tracker;
    TrackEntry             insertEntry;
    logic                  pendingFlush;
    logic                  insertBubble;
    logic                  stallReq;
    logic [SEL_W-1:0]      sel [NUM_SRC];
    logic [NUM_SRC-1:0]    hitLoad;
    logic [NUM_SRC-1:0]    loadEarly;
    logic [NUM_SRC-1:0]    selNonZero;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gOperand
        fwd_match #(
            .REG_W (REG_W),
            .DEPTH (DEPTH)
        ) uMatch (
            .entries   (tracker),
            .srcAddr   (bus.src_addr[i*REG_W +: REG_W]),
            .srcUsed   (bus.src_used[i]),
            .matchSel  (sel[i]),
            .matchLoad (hitLoad[i])
        );

        assign bus.fwd_sel[i*SEL_W +: SEL_W] = sel[i];
        assign loadEarly[i]  = hitLoad[i] && (sel[i] < LOAD_LAT_SEL);
        assign selNonZero[i] = (sel[i] != SEL_W'(SEL_RF));
    end

    // A hold freezes the pipe, so no stall is requested while it is active.
    assign stallReq    = bus.issue_valid && !bus.hold_i && (|loadEarly);
    assign bus.stall_o = stallReq;

    // Stalled, squashed or empty issue slots enter the tracker as bubbles.
    always_comb begin
        insertBubble = stallReq || bus.flush_i || pendingFlush || !bus.issue_valid;
        insertEntry  = '0;
        if (!insertBubble) begin
            insertEntry.valid = 1'b1;
            insertEntry.wr    = bus.issue_wr;
            insertEntry.load  = bus.issue_load;
            insertEntry.dst   = DST_MAX_W'(bus.issue_dst);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracker <= '0;
        end else if (!bus.hold_i) begin
            tracker[0] <= insertEntry;
            for (int k = 1; k < DEPTH; k++) begin
                tracker[k] <= tracker[k-1];
            end
        end
    end

    // A flush seen during a hold is remembered until the first advancing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingFlush <= 1'b0;
        end else if (bus.hold_i) begin
            if (bus.flush_i) begin
                pendingFlush <= 1'b1;
            end
        end else begin
            pendingFlush <= 1'b0;
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] stallCnt;
    logic [15:0] fwdCnt;
    logic        fwdEvent;

    assign fwdEvent = bus.issue_valid && !stallReq && !bus.flush_i &&
                      !pendingFlush && (|selNonZero);

    // Saturating event counters, updated only on advancing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            fwdCnt   <= '0;
        end else if (!bus.hold_i) begin
            if (stallReq && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (fwdEvent && fwdCnt != 16'hFFFF) begin
                fwdCnt <= fwdCnt + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stallCnt;
    assign bus.fwd_cnt   = fwdCnt;
`else
    logic unusedSel;
    assign unusedSel = ^selNonZero;
`endif

endmodule

// File: tb/tb_fwd_track_unit.sv
// Scoreboard bench: two units (DEPTH=2/LOAD_LAT=2 and DEPTH=3/LOAD_LAT=3) share one stimulus
// stream; a queue-based reference model predicts selects, stalls and counters.
module tb_fwd_track_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       issueValid = 1'b0;
    logic       issueWr = 1'b0;
    logic       issueLoad = 1'b0;
    logic [3:0] issueDst = '0;
    logic [3:0] srcReg [3] = '{default: '0};
    logic [2:0] usedVec = '0;
    logic       holdIn = 1'b0;
    logic       flushIn = 1'b0;

    int total = 0;
    int bad = 0;

    fwd_track_unit_if #(.REG_W(4), .NUM_SRC(3), .DEPTH(2)) busA ();
    fwd_track_unit_if #(.REG_W(4), .NUM_SRC(3), .DEPTH(3)) busB ();

    assign busA.issue_valid = issueValid;
    assign busA.issue_wr    = issueWr;
    assign busA.issue_load  = issueLoad;
    assign busA.issue_dst   = issueDst;
    assign busA.src_addr    = {srcReg[2], srcReg[1], srcReg[0]};
    assign busA.src_used    = usedVec;
    assign busA.hold_i      = holdIn;
    assign busA.flush_i     = flushIn;
    assign busB.issue_valid = issueValid;
    assign busB.issue_wr    = issueWr;
    assign busB.issue_load  = issueLoad;
    assign busB.issue_dst   = issueDst;
    assign busB.src_addr    = {srcReg[2], srcReg[1], srcReg[0]};
    assign busB.src_used    = usedVec;
    assign busB.hold_i      = holdIn;
    assign busB.flush_i     = flushIn;

    fwd_track_unit #(.REG_W(4), .NUM_SRC(3), .DEPTH(2), .LOAD_LAT(2)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    fwd_track_unit #(.REG_W(4), .NUM_SRC(3), .DEPTH(3), .LOAD_LAT(3)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    // Reference model: per unit, a list of recent issue slots, youngest first.
    typedef struct {
        bit valid;
        bit wr;
        bit load;
        int dst;
    } Rec;

    typedef struct {
        int selA;
        int selB;
        bit stallA;
        bit stallB;
        int scA;
        int scB;
        int fcA;
        int fcB;
    } Exp;

    Rec hist [2][$];
    int depthOf [2] = '{2, 3};
    int latOf [2] = '{2, 3};
    bit pend [2] = '{0, 0};
    int stallCount [2] = '{0, 0};
    int fwdCount [2] = '{0, 0};
    Exp expQ [$];

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int modelSel(input int u, input int i, output bit early);
        early = 1'b0;
        if (!usedVec[i]) return 0;
        for (int k = 0; k < hist[u].size(); k++) begin
            if (hist[u][k].valid && hist[u][k].wr && hist[u][k].dst != 0 &&
                hist[u][k].dst == int'(srcReg[i])) begin
                early = hist[u][k].load && ((k + 1) < latOf[u]);
                return k + 1;
            end
        end
        return 0;
    endfunction

    function automatic void modelReset();
        for (int u = 0; u < 2; u++) begin
            hist[u].delete();
            pend[u] = 1'b0;
            stallCount[u] = 0;
            fwdCount[u] = 0;
        end
    endfunction

    task automatic applyStimulus(input bit v, input bit wr, input bit ld, input int dst,
                                 input int s0, input int s1, input int s2, input bit [2:0] used,
                                 input bit hold, input bit flush);
        Exp e;
        int selPk [2];
        bit stl [2];
        bit anySel [2];
        bit anyEarly;
        bit early;
        bit bubble;
        int s;
        Rec r;
        @(posedge clk);
        #1;
        issueValid = v;
        issueWr = wr;
        issueLoad = ld;
        issueDst = 4'(dst);
        srcReg[0] = 4'(s0);
        srcReg[1] = 4'(s1);
        srcReg[2] = 4'(s2);
        usedVec = used;
        holdIn = hold;
        flushIn = flush;
        for (int u = 0; u < 2; u++) begin
            selPk[u] = 0;
            anyEarly = 1'b0;
            anySel[u] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                s = modelSel(u, i, early);
                selPk[u] |= s << (4 * i);
                if (early) anyEarly = 1'b1;
                if (s != 0) anySel[u] = 1'b1;
            end
            stl[u] = v && !hold && anyEarly;
        end
        e.selA = selPk[0];
        e.selB = selPk[1];
        e.stallA = stl[0];
        e.stallB = stl[1];
        e.scA = stallCount[0];
        e.scB = stallCount[1];
        e.fcA = fwdCount[0];
        e.fcB = fwdCount[1];
        expQ.push_back(e);
        // Advance the model to the state after the coming clock edge.
        for (int u = 0; u < 2; u++) begin
            if (hold) begin
                if (flush) pend[u] = 1'b1;
            end else begin
                bubble = stl[u] || flush || pend[u] || !v;
                if (stl[u] && stallCount[u] < 65535) stallCount[u]++;
                if (!bubble && anySel[u] && fwdCount[u] < 65535) fwdCount[u]++;
                pend[u] = 1'b0;
                r.valid = !bubble;
                r.wr = bubble ? 1'b0 : wr;
                r.load = bubble ? 1'b0 : ld;
                r.dst = bubble ? 0 : dst;
                hist[u].push_front(r);
                if (hist[u].size() > depthOf[u]) void'(hist[u].pop_back());
            end
        end
    endtask

    task automatic setIdle();
        issueValid = 1'b0;
        issueWr = 1'b0;
        issueLoad = 1'b0;
        issueDst = '0;
        usedVec = '0;
        holdIn = 1'b0;
        flushIn = 1'b0;
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_selA"}, int'(busA.fwd_sel), 0);
        checkOutput({tag, "_selB"}, int'(busB.fwd_sel), 0);
        checkOutput({tag, "_stallA"}, int'(busA.stall_o), 0);
        checkOutput({tag, "_stallB"}, int'(busB.stall_o), 0);
`ifdef FWD_STATS_EN
        checkOutput({tag, "_scA"}, int'(busA.stall_cnt), 0);
        checkOutput({tag, "_fcB"}, int'(busB.fwd_cnt), 0);
`endif
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic doReset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkZeroOutputs(tag);
        modelReset();
        setIdle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected record per issue cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            Exp e;
            e = expQ.pop_front();
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("selA%0d", i), int'(busA.fwd_sel[i*2 +: 2]), (e.selA >> (4 * i)) & 15);
                checkOutput($sformatf("selB%0d", i), int'(busB.fwd_sel[i*2 +: 2]), (e.selB >> (4 * i)) & 15);
            end
            checkOutput("stallA", int'(busA.stall_o), int'(e.stallA));
            checkOutput("stallB", int'(busB.stall_o), int'(e.stallB));
`ifdef FWD_STATS_EN
            checkOutput("stallCntA", int'(busA.stall_cnt), e.scA);
            checkOutput("stallCntB", int'(busB.stall_cnt), e.scB);
            checkOutput("fwdCntA", int'(busA.fwd_cnt), e.fcA);
            checkOutput("fwdCntB", int'(busB.fwd_cnt), e.fcB);
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setIdle();
        rst_n = 1'b0;
        #3;
        checkZeroOutputs("resetInit");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // ALU result forwarded from stage 1, then stage 2, then the register file.
        applyStimulus(1, 1, 0, 3, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 0, 0, 0, 3, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("r3Plus1", int'(busA.fwd_sel[1:0]), 1);
        applyStimulus(1, 0, 0, 0, 3, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("r3Plus2", int'(busA.fwd_sel[1:0]), 2);
        applyStimulus(1, 0, 0, 0, 3, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("r3Plus3", int'(busA.fwd_sel[1:0]), 0);

        // Two writers of r7: the younger one wins; r0 never forwards.
        applyStimulus(1, 1, 0, 7, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 1, 0, 7, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 7, 0, 3'b010, 0, 0);
        #1 checkOutput("r7Youngest", int'(busA.fwd_sel[3:2]), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        #1 checkOutput("r0Sel", int'(busA.fwd_sel), 0);

        // Load-use: unit A stalls once, unit B twice, then both forward from the load's stage.
        applyStimulus(1, 1, 1, 5, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 0, 0, 0, 5, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("loadStallA", int'(busA.stall_o), 1);
        applyStimulus(1, 0, 0, 0, 5, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("loadSelA", int'(busA.fwd_sel[1:0]), 2);
        checkOutput("loadStallB2", int'(busB.stall_o), 1);
        applyStimulus(1, 0, 0, 0, 5, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("loadSelB", int'(busB.fwd_sel[1:0]), 3);
        checkOutput("loadStallB3", int'(busB.stall_o), 0);
        applyStimulus(1, 1, 1, 6, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 0, 0, 0, 6, 0, 0, 3'b000, 0, 0);
        #1 checkOutput("unusedNoStall", int'(busA.stall_o), 0);

        // Flush during a hold: entries freeze, released instruction becomes a bubble.
        applyStimulus(1, 1, 0, 9, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 1, 0, 10, 9, 0, 0, 3'b001, 1, 1);
        applyStimulus(1, 1, 0, 10, 9, 0, 0, 3'b001, 1, 0);
        applyStimulus(1, 1, 0, 10, 9, 0, 0, 3'b001, 1, 0);
        applyStimulus(1, 1, 0, 11, 9, 0, 0, 3'b001, 0, 0);
        #1 checkOutput("holdFrozen", int'(busA.fwd_sel[1:0]), 1);
        applyStimulus(1, 0, 0, 0, 11, 9, 0, 3'b011, 0, 0);
        #1 checkOutput("releasedDropped", int'(busA.fwd_sel[1:0]), 0);
        checkOutput("bubbleShift", int'(busA.fwd_sel[3:2]), 2);

        // Reset while both units are stalled on a load.
        applyStimulus(1, 1, 1, 4, 0, 0, 0, 3'b000, 0, 0);
        applyStimulus(1, 0, 0, 0, 4, 0, 0, 3'b001, 0, 0);
        doReset("resetMidStall");

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 5),
                          $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                          3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #1;
        checkOutput("queueDrained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_track_unit.md
# fwd_track_unit

Parametrised forwarding and hazard unit that succeeds the fixed two-stage combinational forwarding logic. It keeps its own shift-register record of in-flight destination writes, so the pipeline does not have to route EX/MEM and MEM/WB register fields back to it. It sits beside the ID/EX boundary and drives the operand bypass mux selects and a load-use stall for a configurable number of source operands and tracked stages.

## Interface
- `REG_W`, default 4: register address width; register 0 is hardwired zero.
- `NUM_SRC`, default 3: source operands checked per issue (src1, src2, LLB/LHB dst-as-source).
- `DEPTH`, default 2: post-issue stages tracked; stage 1 = EX/MEM, stage `DEPTH` = oldest.
- `LOAD_LAT`, default 2: first stage index at which load data is forwardable; legal range 1..`DEPTH`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `issue_valid` input 1: ID-stage instruction valid.
- `issue_wr` input 1: issuing instruction writes a register.
- `issue_load` input 1: issuing instruction is a load.
- `issue_dst` input `REG_W`: issuing destination register.
- `src_addr` input `NUM_SRC*REG_W`: source registers; operand i occupies bits [i*REG_W +: REG_W].
- `src_used` input `NUM_SRC`: bit i set when operand i is actually read.
- `hold_i` input 1: external pipeline freeze (e.g. memory wait).
- `flush_i` input 1: squash the issuing instruction (taken branch).
- `fwd_sel` output `NUM_SRC*SEL_W`, where `SEL_W` = clog2(`DEPTH`+1): per-operand bypass select; 0 selects the register file, k selects stage k.
- `stall_o` output 1: load-use stall request to PC/IF/ID.
- `stall_cnt` output 16 (`FWD_STATS_EN` only): cycles stalled.
- `fwd_cnt` output 16 (`FWD_STATS_EN` only): issues with at least one nonzero select.

## Operation
- Tracker has `DEPTH` entries, each holding {valid, wr, load, dst}.
- A stage k matches operand i when: entry valid, wr set, dst != 0, dst == src i, and `src_used`[i] set.
- `fwd_sel`[i] is the smallest (youngest) matching k, or 0 if no stage matches. The youngest writer always wins.
- A hazard exists when `issue_valid` is set and, for any operand, the youngest match is a load entry with k < `LOAD_LAT`. Then `stall_o` = 1.
- During a stall, `fwd_sel` is still driven, but downstream logic ignores it.
- Insert value for stage 1 each advancing edge:
  - bubble (valid = 0) if `stall_o`, `flush_i`, the pending-flush flag, or `!issue_valid`;
  - otherwise {1, `issue_wr`, `issue_load`, `issue_dst`}.
- Advance: stage k <= stage k-1 for k = 2..`DEPTH`; stage 1 <= insert value.
- While `hold_i` = 1:
  - all entries freeze and `stall_o` is forced to 0;
  - `flush_i` asserted during hold sets a pending-flush flag.
- The pending-flush flag makes the first non-hold edge insert a bubble, then clears. A `flush_i` on that same edge is absorbed, giving one bubble total.
- Elaboration fails if `LOAD_LAT` is outside 1..`DEPTH`.

## Timing
- `fwd_sel` and `stall_o` are combinational from current tracker state and issue inputs, valid in the same cycle.
- Tracker updates on the rising edge of `clk`.
- ALU result is forwardable the cycle after issue (k = 1).
- Load result, with `LOAD_LAT` = L, incurs L-1 stall cycles when consumed immediately.
- Stall cycles insert bubbles, so the load advances while ID holds. `stall_o` deasserts exactly when the load reaches stage L.
- Asynchronous reset, including mid-stall:
  - all entries invalid and pending-flush = 0;
  - hence `fwd_sel` = 0 and `stall_o` = 0 immediately;
  - counters = 0.
- Entries past stage `DEPTH` are dropped; the register file holds their values.

## Configuration
- `FWD_STATS_EN` defined:
  - `stall_cnt` increments on each non-hold cycle with `stall_o` = 1.
  - `fwd_cnt` increments on each non-hold, non-stall, unflushed valid issue with any `fwd_sel` != 0.
  - Both saturate at 16'hFFFF.
- `FWD_STATS_EN` undefined: both ports and all counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `fwd_pkg`:
  - entry struct typedef {valid, wr, load, dst};
  - `SEL_W` function;
  - `SEL_RF` constant = 0.
- Sub-module `fwd_match`: one per operand (generate loop). Inputs are the tracker array and one source; outputs are the youngest-match index and its load flag.
- Top level owns the tracker, the pending-flush flag, the stall OR-reduce and the counters.

## Test plan
- Defaults; issue write r3, then read r3 as src1 on cycles +1, +2, +3 -> `fwd_sel`[0] = 1, 2, 0.
- Stage 1 and stage 2 both write r7; src2 = r7 -> select 1. src = r0 with `issue_wr`/dst = r0 -> select 0, no stall.
- Load r5, then read r5 -> `stall_o` = 1 for one cycle, bubble inserted; next cycle select = 2, `stall_o` = 0. `src_used` cleared -> no stall.
- `LOAD_LAT` = 3, `DEPTH` = 3; load r2 consumed next -> two stall cycles, then select 3.
- `flush_i` asserted during a 3-cycle `hold_i` -> entries frozen; one bubble on release; released instruction not recorded.
- `FWD_STATS_EN` with a stall and forward mix -> counters match the scoreboard. `rst_n` low mid-stall -> all outputs 0 asynchronously.
